// File: rtl/input_controller.sv
// Button front end: two-flop synchronisers, per-button debounce, level
// plus release-pulse packing, and a vsync-derived game-tick trigger.
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TRIGGER_FRAMES  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  input  logic       vsync,
  output logic [9:0] input_data,
  output logic       trigger
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int FW =
    (TRIGGER_FRAMES > 1) ? $clog2(TRIGGER_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_MAX =
    FW'(TRIGGER_FRAMES - 1);

  logic [4:0]          btn_s1_q, btn_s1_d;
  logic [4:0]          btn_s2_q, btn_s2_d;
  logic [4:0]          stable_q, stable_d;
  logic [4:0]          rel_q, rel_d;
  logic [4:0][CW-1:0]  cnt_q, cnt_d;

  logic                vs_s1_q, vs_s1_d;
  logic                vs_s2_q, vs_s2_d;
  logic                vs_dly_q, vs_dly_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                trig_q, trig_d;
  logic                vs_rise;

  always_comb begin
    btn_s1_d = btn_raw;
    btn_s2_d = btn_s1_q;
    stable_d = stable_q;
    rel_d    = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (btn_s2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = btn_s2_q[i];
        cnt_d[i]    = '0;
        // Only a committed 1->0 change pulses the release bit.
        rel_d[i]    = stable_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign vs_rise = vs_s2_q & ~vs_dly_q;

  always_comb begin
    vs_s1_d  = vsync;
    vs_s2_d  = vs_s1_q;
    vs_dly_d = vs_s2_q;
    frame_d  = frame_q;
    trig_d   = 1'b0;
    if (vs_rise) begin
      if (frame_q == FRAME_MAX) begin
        frame_d = '0;
        trig_d  = 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      stable_q <= '0;
      rel_q    <= '0;
      cnt_q    <= '0;
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_dly_q <= 1'b0;
      frame_q  <= '0;
      trig_q   <= 1'b0;
    end else begin
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
      stable_q <= stable_d;
      rel_q    <= rel_d;
      cnt_q    <= cnt_d;
      vs_s1_q  <= vs_s1_d;
      vs_s2_q  <= vs_s2_d;
      vs_dly_q <= vs_dly_d;
      frame_q  <= frame_d;
      trig_q   <= trig_d;
    end
  end

  assign input_data = {stable_q, rel_q};
  assign trigger    = trig_q;

endmodule

// File: tb/tb_input_controller.sv
// Bench for input_controller: directed scenarios plus random traffic,
// every cycle compared against a history-based behavioural model.
module tb_input_controller;

  localparam int DB = 4;
  localparam int TF = 3;

  logic       clk;
  logic       reset;
  logic [4:0] btn_raw;
  logic       vsync;
  logic [9:0] input_data;
  logic       trigger;

  int checks;
  int errors;
  int trig_seen;

  input_controller #(
    .DEBOUNCE_CYCLES(DB),
    .TRIGGER_FRAMES (TF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .vsync     (vsync),
    .input_data(input_data),
    .trigger   (trigger)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: sync pipelines, last DB synchronised samples, levels.
  logic [4:0] m_s1, m_s2, m_stable, exp_pulse;
  logic [4:0] hist [DB];
  logic       m_vs1, m_vs2, m_vsd, exp_trig;
  int         rises;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_stable = '0; exp_pulse = '0;
    for (int k = 0; k < DB; k++) hist[k] = '0;
    m_vs1 = 0; m_vs2 = 0; m_vsd = 0; exp_trig = 0;
    rises = 0;
  endtask

  task automatic model_edge();
    logic [4:0] s2_old;
    logic       rise;
    bit         differ;
    if (!reset) begin
      model_clear();
      return;
    end
    s2_old = m_s2;
    for (int k = DB - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s2_old;
    exp_pulse = '0;
    for (int i = 0; i < 5; i++) begin
      differ = 1;
      for (int k = 0; k < DB; k++)
        if (hist[k][i] == m_stable[i]) differ = 0;
      if (differ) begin
        exp_pulse[i] = m_stable[i];
        m_stable[i]  = s2_old[i];
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
    rise  = m_vs2 & ~m_vsd;
    m_vsd = m_vs2;
    m_vs2 = m_vs1;
    m_vs1 = vsync;
    exp_trig = 0;
    if (rise) begin
      rises++;
      exp_trig = (rises % TF) == 0;
    end
  endtask

  task automatic chk10(string tag, logic [9:0] obs, logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk10("input_data", input_data, {m_stable, exp_pulse});
    chk1("trigger", trigger, exp_trig);
    if (trigger === 1'b1) trig_seen++;
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    checks = 0; errors = 0; trig_seen = 0;
    model_clear();
    reset = 0; btn_raw = '0; vsync = 0;
    steps(3);
    chk10("reset_data", input_data, 10'h000);
    chk1("reset_trig", trigger, 1'b0);
    reset = 1;
    steps(4);

    // Press up: visible on exactly the sixth edge.
    btn_raw = 5'b00001;
    steps(5);
    chk10("t1_before", input_data, 10'h000);
    step();
    chk10("t1_level", input_data, 10'b00001_00000);
    steps(4);
    chk10("t1_hold", input_data, 10'b00001_00000);

    // Release up: one-cycle pulse on bit 0.
    btn_raw = 5'b00000;
    steps(6);
    chk10("t2_pulse", input_data, 10'b00000_00001);
    step();
    chk10("t2_idle", input_data, 10'h000);

    // Short attack glitch is rejected.
    btn_raw = 5'b10000;
    steps(3);
    btn_raw = 5'b00000;
    steps(10);
    chk10("t3_glitch", input_data, 10'h000);

    // Right held, attack added then released.
    btn_raw = 5'b01000;
    steps(8);
    chk10("t4_right", input_data, 10'b01000_00000);
    btn_raw = 5'b11000;
    steps(8);
    chk10("t4_both", input_data, 10'b11000_00000);
    btn_raw = 5'b01000;
    steps(6);
    chk10("t4_rel", input_data, 10'b01000_10000);
    step();
    chk10("t4_after", input_data, 10'b01000_00000);
    btn_raw = 5'b00000;
    steps(10);

    // Seven vsync pulses give exactly two triggers.
    trig_seen = 0;
    for (int p = 0; p < 7; p++) begin
      vsync = 1; steps(3);
      vsync = 0; steps(3);
    end
    steps(4);
    chk1("t5_two", trig_seen == 2, 1'b1);

    // Held left through a one-cycle reset.
    btn_raw = 5'b00100;
    steps(8);
    chk10("t6_level", input_data, 10'b00100_00000);
    reset = 0;
    step();
    chk10("t6_reset", input_data, 10'h000);
    reset = 1;
    steps(5);
    chk10("t6_wait", input_data, 10'h000);
    step();
    chk10("t6_again", input_data, 10'b00100_00000);

    // Random traffic, including glitches and occasional reset.
    for (int r = 0; r < 300; r++) begin
      if ($urandom_range(3) == 0)
        btn_raw = btn_raw ^ (5'd1 << $urandom_range(4));
      else if ($urandom_range(5) == 0)
        btn_raw = 5'($urandom);
      if ($urandom_range(2) == 0) vsync = ~vsync;
      if ($urandom_range(60) == 0) reset = 0;
      steps($urandom_range(1, 8));
      reset = 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
